// File: rtl/block_classify_ctrl_pkg.sv
// Shared types and constants for the block background-subtraction stage.
package block_pkg;

  localparam int unsigned BLOCK_W        = 128;
  localparam int unsigned PIX_W          = 8;
  localparam int unsigned PIX_PER_BLOCK  = 16;
  localparam int unsigned BG_ALPHA_SHIFT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_CLASS,
    ST_WRITE,
    ST_DONE
  } ctrl_state_t;

  // Running-average step: bg + floor((pix - bg) / 2^BG_ALPHA_SHIFT); the
  // true result always lies in 0..255, so the low byte of the sum is exact.
  function automatic logic [PIX_W-1:0] bg_blend(input logic [PIX_W-1:0] pix,
                                                input logic [PIX_W-1:0] bg);
    logic signed [PIX_W:0]   diff;
    logic signed [PIX_W:0]   step;
    logic        [PIX_W:0]   sum;
    diff = $signed({1'b0, pix}) - $signed({1'b0, bg});
    step = diff >>> BG_ALPHA_SHIFT;
    sum  = {1'b0, bg} + step;
    return sum[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/block_classify_ctrl_if.sv
// Block-buffer read port and mask/background write-back port of the sequencer.
interface block_classify_ctrl_if
  import block_pkg::*;
#(
  parameter int unsigned ADDR_W = 15
) ();

  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_valid;
  logic [BLOCK_W-1:0] rd_pix;
  logic [BLOCK_W-1:0] rd_bg;

  logic               wr_valid;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_addr;
  logic [BLOCK_W-1:0] wr_data;

  logic               bg_wr_valid;
  logic [BLOCK_W-1:0] bg_wr_data;

  modport master (
    output rd_req, rd_addr,
    input  rd_valid, rd_pix, rd_bg,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output bg_wr_valid, bg_wr_data
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_valid, rd_pix, rd_bg,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  bg_wr_valid, bg_wr_data
  );

endinterface

// File: rtl/block_classify_ctrl_bg_update.sv
// Per-byte background update: blend pixels flagged as background (mask byte 0).
module bg_update
  import block_pkg::*;
(
  input  logic [BLOCK_W-1:0] pix,
  input  logic [BLOCK_W-1:0] bg,
  input  logic [BLOCK_W-1:0] bin,
  output logic [BLOCK_W-1:0] bg_next
);

  always_comb begin
    bg_next = bg;
    for (int unsigned i = 0; i < PIX_PER_BLOCK; i++) begin
      if (bin[i*PIX_W +: PIX_W] == '0)
        bg_next[i*PIX_W +: PIX_W] = bg_blend(pix[i*PIX_W +: PIX_W], bg[i*PIX_W +: PIX_W]);
    end
  end

endmodule

// File: rtl/block_classify_ctrl.sv
// Frame sequencer: read block, classify, write mask block, repeat over the frame.
// Optional background write-back enabled by BLOCK_CLASSIFY_BG_UPDATE_EN.
module block_classify_ctrl
  import block_pkg::*;
#(
  parameter int unsigned BLOCKS_X = 40,
  parameter int unsigned BLOCKS_Y = 480,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [BLOCK_W-1:0] cls_in,
  output logic [BLOCK_W-1:0] cls_bg,
  input  logic [BLOCK_W-1:0] cls_bin,
  block_classify_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(BLOCKS_X * BLOCKS_Y - 1);

  ctrl_state_t       state, state_nxt;
  logic [ADDR_W-1:0] blk_cnt;
  logic [BLOCK_W-1:0] wr_data_q;
  logic              wr_fire;

  assign wr_fire = (state == ST_WRITE) && bus.wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Abort wins over rd_valid in WAIT; in WRITE it only takes effect on handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_READ;
      ST_READ:  state_nxt = abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (abort)             state_nxt = ST_IDLE;
        else if (bus.rd_valid) state_nxt = ST_CLASS;
      end
      ST_CLASS: state_nxt = abort ? ST_IDLE : ST_WRITE;
      ST_WRITE: begin
        if (wr_fire) begin
          if (abort)                   state_nxt = ST_IDLE;
          else if (blk_cnt == LAST_BLK) state_nxt = ST_DONE;
          else                         state_nxt = ST_READ;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt   <= '0;
      cls_in    <= '0;
      cls_bg    <= '0;
      wr_data_q <= '0;
    end else begin
      if (state == ST_IDLE && start)
        blk_cnt <= '0;
      else if (state == ST_WRITE && state_nxt == ST_READ)
        blk_cnt <= blk_cnt + 1'b1;

      if (state == ST_WAIT && bus.rd_valid && !abort) begin
        cls_in <= bus.rd_pix;
        cls_bg <= bus.rd_bg;
      end

      if (state == ST_CLASS)
        wr_data_q <= cls_bin;
    end
  end

  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign bus.rd_req   = (state == ST_READ);
  assign bus.rd_addr  = blk_cnt;
  assign bus.wr_valid = (state == ST_WRITE);
  assign bus.wr_addr  = blk_cnt;
  assign bus.wr_data  = wr_data_q;

`ifdef BLOCK_CLASSIFY_BG_UPDATE_EN
  logic [BLOCK_W-1:0] bg_next;
  logic [BLOCK_W-1:0] bg_wr_data_q;

  bg_update u_bg_update (
    .pix     (cls_in),
    .bg      (cls_bg),
    .bin     (cls_bin),
    .bg_next (bg_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                bg_wr_data_q <= '0;
    else if (state == ST_CLASS) bg_wr_data_q <= bg_next;
  end

  assign bus.bg_wr_valid = (state == ST_WRITE);
  assign bus.bg_wr_data  = bg_wr_data_q;
`else
  assign bus.bg_wr_valid = 1'b0;
  assign bus.bg_wr_data  = '0;
`endif

endmodule

// File: tb/tb_block_classify_ctrl.sv
// Scoreboard bench for block_classify_ctrl on a 2x2-block frame.
module tb_block_classify_ctrl;
  import block_pkg::*;

  localparam int unsigned BX   = 2;
  localparam int unsigned BY   = 2;
  localparam int unsigned AW   = 4;
  localparam int unsigned NBLK = BX * BY;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  logic [BLOCK_W-1:0] cls_in, cls_bg, cls_bin;

  block_classify_ctrl_if #(.ADDR_W(AW)) bus ();

  block_classify_ctrl #(.BLOCKS_X(BX), .BLOCKS_Y(BY), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .cls_in  (cls_in),
    .cls_bg  (cls_bg),
    .cls_bin (cls_bin),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [BLOCK_W-1:0] pix_mem [NBLK];
  logic [BLOCK_W-1:0] bg_mem  [NBLK];
  logic               use_bin_ovr = 1'b0;
  logic [BLOCK_W-1:0] bin_ovr     = '0;

  // Classifier stand-in: inverted pixels, or a fixed mask for the bg cases.
  assign cls_bin = use_bin_ovr ? bin_ovr : ~cls_in;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [BLOCK_W-1:0] got,
                       input logic [BLOCK_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0]      addr;
    logic [BLOCK_W-1:0] data;
    logic [BLOCK_W-1:0] bg;
  } exp_t;

  exp_t sb[$];

  function automatic logic [7:0] bg_model(input logic [7:0] p, input logic [7:0] b);
    int d, s;
    d = int'(p) - int'(b);
    s = (d >= 0) ? d / 8 : -((-d + 7) / 8);
    return 8'(int'(b) + s);
  endfunction

  function automatic logic [BLOCK_W-1:0] bg_block(input logic [BLOCK_W-1:0] p,
                                                  input logic [BLOCK_W-1:0] b,
                                                  input logic [BLOCK_W-1:0] m);
    logic [BLOCK_W-1:0] r;
    r = b;
    for (int i = 0; i < 16; i++)
      if (m[i*8 +: 8] == 8'h00) r[i*8 +: 8] = bg_model(p[i*8 +: 8], b[i*8 +: 8]);
    return r;
  endfunction

  task automatic push_frame(input int unsigned first, input int unsigned last);
    exp_t e;
    for (int unsigned a = first; a <= last; a++) begin
      e.addr = AW'(a);
      e.data = use_bin_ovr ? bin_ovr : ~pix_mem[a];
`ifdef BLOCK_CLASSIFY_BG_UPDATE_EN
      e.bg   = bg_block(pix_mem[a], bg_mem[a], e.data);
`else
      e.bg   = '0;
`endif
      sb.push_back(e);
    end
  endtask

  int unsigned cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder, sink ready control and write monitor share one process.
  int unsigned        rd_lat    = 2;
  int unsigned        due_q[$];
  logic [AW-1:0]      due_addr[$];
  int unsigned        hold_addr = 99;
  int unsigned        hold_left = 0;
  int unsigned        stall_seen = 0;
  int unsigned        last_hs_cyc = 0;
  int unsigned        done_cnt = 0;
  int unsigned        done_cyc = 0;
  int unsigned        gap [NBLK];
  logic [BLOCK_W-1:0] hs_bg [NBLK];

  initial begin
    logic               prev_stall;
    logic [AW-1:0]      st_addr;
    logic [BLOCK_W-1:0] st_data;
    logic [AW-1:0]      a;
    exp_t               e;
    prev_stall   = 1'b0;
    st_addr      = '0;
    st_data      = '0;
    bus.rd_valid = 1'b0;
    bus.rd_pix   = '0;
    bus.rd_bg    = '0;
    bus.wr_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.rd_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        a = due_addr.pop_front();
        bus.rd_valid = 1'b1;
        bus.rd_pix   = pix_mem[a % NBLK];
        bus.rd_bg    = bg_mem[a % NBLK];
      end
      if (bus.rd_req === 1'b1) begin
        due_q.push_back(cyc + rd_lat);
        due_addr.push_back(bus.rd_addr);
      end

      if (bus.wr_valid && bus.wr_addr == hold_addr && hold_left > 0) begin
        bus.wr_ready = 1'b0;
        hold_left--;
        stall_seen++;
      end else begin
        bus.wr_ready = 1'b1;
      end

      if (prev_stall) begin
        check("stall_valid", bus.wr_valid, 1);
        check("stall_addr", bus.wr_addr, st_addr);
        check("stall_data", bus.wr_data, st_data);
      end
      if (bus.wr_valid) check("rd_req_in_write", bus.rd_req, 0);
      prev_stall = bus.wr_valid && !bus.wr_ready;
      st_addr    = bus.wr_addr;
      st_data    = bus.wr_data;

      if (bus.wr_valid && bus.wr_ready) begin
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("wr_addr", bus.wr_addr, e.addr);
          check("wr_data", bus.wr_data, e.data);
`ifdef BLOCK_CLASSIFY_BG_UPDATE_EN
          check("bg_wr_valid", bus.bg_wr_valid, 1);
`else
          check("bg_wr_valid", bus.bg_wr_valid, 0);
`endif
          check("bg_wr_data", bus.bg_wr_data, e.bg);
        end
        if (bus.wr_addr < NBLK) begin
          gap[bus.wr_addr]   = cyc - last_hs_cyc;
          hs_bg[bus.wr_addr] = bus.bg_wr_data;
        end
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  task automatic wait_done(input int unsigned max);
    int unsigned n = 0;
    int unsigned d0 = done_cnt;
    while (done_cnt == d0 && n < max) begin
      tick();
      n++;
    end
    check("done_timeout", n < max, 1);
  endtask

  task automatic wait_rd(input int unsigned addr, input string tag);
    int unsigned n = 0;
    while (!(bus.rd_req === 1'b1 && bus.rd_addr == addr) && n < 100) begin
      tick();
      n++;
    end
    check(tag, n < 100, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic        any_out;
    int unsigned d0;
    for (int i = 0; i < NBLK; i++) begin
      pix_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      bg_mem[i]  = {$urandom, $urandom, $urandom, $urandom};
    end

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ctrl", {busy, done, bus.rd_req, bus.wr_valid, bus.bg_wr_valid}, 0);
    check("rst_addr", {bus.rd_addr, bus.wr_addr}, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_cls", cls_in | cls_bg, 0);
    rst_n = 1'b1;
    any_out = 1'b0;
    repeat (20) begin
      tick();
      any_out |= busy | done | bus.rd_req | bus.wr_valid | bus.bg_wr_valid
               | (|bus.rd_addr) | (|bus.wr_addr) | (|bus.wr_data)
               | (|bus.bg_wr_data) | (|cls_in) | (|cls_bg);
    end
    check("idle_outputs", any_out, 0);

    // Full frame, L=2, start coincident with DONE ignored
    rd_lat = 2;
    push_frame(0, NBLK - 1);
    d0 = done_cnt;
    tick();
    start_frame();
    check("first_rd_addr", bus.rd_addr, 0);
    wait_done(200);
    check("done_lag", done_cyc - last_hs_cyc, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_done", busy, 0);
    check("done_width", done, 0);
    for (int unsigned b = 1; b < NBLK; b++) check("block_cycles", gap[b], 5);
    repeat (3) tick();
    check("start_at_done_ignored", busy, 0);
    check("done_count", done_cnt - d0, 1);
    check("sb_empty_frame", sb.size(), 0);

    // Backpressure on block 1
    push_frame(0, NBLK - 1);
    hold_addr  = 1;
    hold_left  = 7;
    stall_seen = 0;
    start_frame();
    wait_done(200);
    check("stall_cycles", stall_seen, 7);
    check("stall_gap", gap[1], 12);
    check("post_stall_gap", gap[2], 5);
    hold_addr = 99;
    repeat (2) tick();
    check("sb_empty_bp", sb.size(), 0);

    // Abort during WAIT of block 2, late rd_valid ignored, then restart
    rd_lat = 3;
    push_frame(0, 1);
    d0 = done_cnt;
    start_frame();
    wait_rd(2, "abort_target_seen");
    tick();
    check("in_wait", {busy, bus.rd_req, bus.wr_valid}, 3'b100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", busy, 0);
    repeat (5) tick();
    check("late_rd_ignored", cls_in, pix_mem[1]);
    check("abort_stays_idle", {busy, bus.wr_valid, bus.rd_req}, 0);
    check("abort_no_done", done_cnt - d0, 0);
    check("sb_empty_abort", sb.size(), 0);
    rd_lat = 2;
    push_frame(0, NBLK - 1);
    start_frame();
    check("restart_addr", {bus.rd_req, bus.rd_addr}, {1'b1, AW'(0)});
    wait_done(200);
    repeat (2) tick();

    // Start pulsed mid-frame is ignored
    push_frame(0, NBLK - 1);
    d0 = done_cnt;
    start_frame();
    wait_rd(1, "midframe_rd_seen");
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200);
    repeat (4) tick();
    check("midstart_done_count", done_cnt - d0, 1);
    check("midstart_idle", busy, 0);
    check("sb_empty_midstart", sb.size(), 0);

`ifdef BLOCK_CLASSIFY_BG_UPDATE_EN
    // Background update byte cases
    pix_mem[0][7:0]   = 8'h80;  bg_mem[0][7:0]   = 8'h40;
    pix_mem[0][15:8]  = 8'h00;  bg_mem[0][15:8]  = 8'h07;
    pix_mem[0][23:16] = 8'h80;  bg_mem[0][23:16] = 8'h40;
    bin_ovr           = {$urandom, $urandom, $urandom, $urandom};
    bin_ovr[23:0]     = 24'hFF0000;
    use_bin_ovr       = 1'b1;
    push_frame(0, NBLK - 1);
    start_frame();
    wait_done(200);
    repeat (2) tick();
    check("bg_byte0", hs_bg[0][7:0], 8'h48);
    check("bg_byte1", hs_bg[0][15:8], 8'h06);
    check("bg_byte2_fg", hs_bg[0][23:16], 8'h40);
    use_bin_ovr = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
